sc_randreg: RTL and testbench
=============================

Name: sc_randreg

Overview:
- Parametrised successor to the debounce + state-machine + random-source + general-register chain.
- Merges into one block:
  - a Galois LFSR with configurable width, taps, seed and run mode;
  - one-shot edge detection of active-low clear/load requests;
  - a capture register;
  - a capture-history FIFO.
- Sits after the debouncers; drives the data output bus of the system top.

Parameters:
- DATAWIDTH, 8, LFSR/register/FIFO word width, legal 4..32.
- TAPS, 8'hB8, Galois feedback mask, DATAWIDTH bits; MSB must be 1.
- SEED, 8'h01, LFSR reset/recovery value, DATAWIDTH bits, nonzero.
- DEPTH, 4, FIFO entries, power of 2, 2..16.

Ports:
- SC_RANDREG_CLOCK_50  in  1  system clock, all logic on rising edge.
- SC_RANDREG_RESET_InHigh  in  1  synchronous active-high reset.
- SC_RANDREG_clear_InLow  in  1  debounced clear request, active low.
- SC_RANDREG_load_InLow  in  1  debounced load request, active low.
- SC_RANDREG_mode_In  in  2  LFSR mode: 00 hold, 01 free-run, 10 single-step, 11 reseed.
- SC_RANDREG_step_In  in  1  advance strobe, used in mode 10.
- SC_RANDREG_seed_InBUS  in  DATAWIDTH  reseed value, used in mode 11.
- SC_RANDREG_pop_In  in  1  FIFO read strobe.
- SC_RANDREG_lfsr_OutBUS  out  DATAWIDTH  current LFSR state.
- SC_RANDREG_data_OutBUS  out  DATAWIDTH  capture register.
- SC_RANDREG_fifo_data_OutBUS  out  DATAWIDTH  FIFO head (first-word fall-through); 0 when empty.
- SC_RANDREG_fifo_empty_Out  out  1  FIFO empty.
- SC_RANDREG_fifo_full_Out  out  1  FIFO full.
- SC_RANDREG_overflow_Out  out  1  sticky; set when a push is dropped.
- SC_RANDREG_load_done_Out  out  1  one-cycle pulse, registered, on every capture.

Behaviour:
- One clock. Reset is synchronous and active-high, sampled on the rising edge; it overrides all other inputs.
- Reset values:
  - lfsr = SEED; data = 0;
  - FIFO empty (empty=1, full=0, fifo_data=0);
  - overflow = 0; load_done = 0;
  - edge-detect history registers = 1 (released).
- LFSR step function: next = (s>>1) ^ (s[0] ? TAPS : 0).
- LFSR per edge, by mode:
  - 00 hold.
  - 01 step every cycle.
  - 10 step only when step_In=1.
  - 11 load seed_InBUS; a seed of 0 loads SEED instead (lock-up guard).
  - Any state of 0, whatever its cause, is replaced by SEED on the next edge.
- Edge detect:
  - load_evt = load_prev & ~load_InLow; clear_evt likewise.
  - Both are combinational from the history register and the live input.
  - A held-low input produces exactly one event; re-arming requires a return high.
- clear_evt: data <= 0; FIFO flushed; overflow <= 0; no load_done.
- load_evt with no clear_evt, same edge:
  - data <= lfsr value before that edge's step.
  - That value is pushed into the FIFO.
  - load_done = 1 in the following cycle.
- clear_evt and load_evt on the same edge: clear wins and the load is discarded. The load input must return high before it re-arms.
- FIFO push:
  - Push when full and no pop: word dropped, overflow set (sticky until clear or reset); data register still updates.
  - Push and pop together when full: both happen; count unchanged; no overflow.
  - Push and pop together when empty: the pop is ignored and the push lands.
- FIFO pop:
  - Pop when empty is ignored with no error.
  - Head advances on the edge.
- Flag timing: empty/full are registered and reflect count after the edge. Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- LFSR is unaffected by clear and by FIFO activity.

Decomposition:
- Shared package sc_randreg_pkg: mode encodings (MODE_HOLD, MODE_RUN, MODE_STEP, MODE_SEED).
- One sub-module sc_randreg_fifo (parametrised DATAWIDTH, DEPTH; push, pop, flush, head, empty, full, overflow).
- LFSR, edge detectors and capture register stay in the top.

Test Plan (DATAWIDTH=8, TAPS=B8, SEED=01):
- Reset, then mode 01 for 5 cycles:
  - lfsr_OutBUS = 01, B8, 5C, 2E, 17, B3.
  - Outputs hold reset values throughout.
- Mode 01: load_InLow falls while lfsr=5C, held low 10 cycles:
  - data=5C, exactly one load_done pulse, FIFO count 1, head=5C.
- Mode 10, five loads with no pop (DEPTH 4):
  - first four pushed, full=1.
  - fifth: overflow=1, data updated, FIFO contents unchanged.
  - pop 4: heads in order; then empty=1, head=00.
- clear and load fall on the same edge with data=2E and FIFO non-empty:
  - data=00, FIFO empty, overflow=0, no load_done.
- Mode 11 with seed 00, then seed 3C:
  - lfsr=01 after the first; lfsr=3C after the second.
  - Mode 00 holds 3C.
- Reset asserted mid-sequence (FIFO holding 3, overflow=1, lfsr=B3):
  - all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/sc_randreg_pkg.sv
// Shared definitions for sc_randreg: LFSR mode encodings and the Galois step helper.
// The step helper works on 32-bit words; callers zero-extend and truncate to their width.
package sc_randreg_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_RUN  = 2'b01,
      MODE_STEP = 2'b10,
      MODE_SEED = 2'b11
   } lfsr_mode_e;

   // Right-shifting Galois step: the bit shifted out selects whether the tap mask is folded in.
   function automatic logic [31:0] galois_step(input logic [31:0] state, input logic [31:0] taps);
      logic [31:0] shifted;
      shifted = state >> 1;
      return state[0] ? (shifted ^ taps) : shifted;
   endfunction

endpackage

// File: rtl/sc_randreg_fifo.sv
// Capture-history FIFO with first-word fall-through head, registered flags and sticky overflow.
// Strobes: push_i/pop_i are single-cycle requests acted on at the rising edge; flush_i beats both.
module sc_randreg_fifo
   import sc_randreg_pkg::*;
#(
   parameter int DATAWIDTH = 8,
   parameter int DEPTH     = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 push_i,
   input  logic [DATAWIDTH-1:0] push_data_i,
   input  logic                 pop_i,
   input  logic                 flush_i,
   output logic [DATAWIDTH-1:0] head_o,
   output logic                 empty_o,
   output logic                 full_o,
   output logic                 overflow_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [DATAWIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 empty_q, full_q;
   logic                 overflow_q, overflow_d;
   logic                 do_push, do_pop, wr_en;

   always_comb begin
      do_pop     = pop_i & ~empty_q;
      // A push into a full FIFO only lands if a pop frees a slot on the same edge.
      do_push    = push_i & (~full_q | do_pop);
      wr_en      = do_push & ~flush_i & ~rst_i;
      wr_ptr_d   = wr_ptr_q + AW'(do_push);
      rd_ptr_d   = rd_ptr_q + AW'(do_pop);
      count_d    = count_q + CW'(do_push) - CW'(do_pop);
      overflow_d = overflow_q | (push_i & ~do_push);
      if (flush_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= (count_d == '0);
         full_q     <= (count_d == CW'(DEPTH));
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: the head is masked while empty.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o     = empty_q ? '0 : mem_q[rd_ptr_q];
   assign empty_o    = empty_q;
   assign full_o     = full_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/sc_randreg.sv
// Random-register block: Galois LFSR, one-shot clear/load edge detect, capture register
// and a capture-history FIFO, all on one rising-edge clock with synchronous reset.
module sc_randreg
   import sc_randreg_pkg::*;
#(
   parameter int                   DATAWIDTH = 8,
   parameter logic [DATAWIDTH-1:0] TAPS      = DATAWIDTH'(8'hB8),
   parameter logic [DATAWIDTH-1:0] SEED      = DATAWIDTH'(8'h01),
   parameter int                   DEPTH     = 4
) (
   input  logic                 SC_RANDREG_CLOCK_50,
   input  logic                 SC_RANDREG_RESET_InHigh,
   input  logic                 SC_RANDREG_clear_InLow,
   input  logic                 SC_RANDREG_load_InLow,
   input  logic [1:0]           SC_RANDREG_mode_In,
   input  logic                 SC_RANDREG_step_In,
   input  logic [DATAWIDTH-1:0] SC_RANDREG_seed_InBUS,
   input  logic                 SC_RANDREG_pop_In,
   output logic [DATAWIDTH-1:0] SC_RANDREG_lfsr_OutBUS,
   output logic [DATAWIDTH-1:0] SC_RANDREG_data_OutBUS,
   output logic [DATAWIDTH-1:0] SC_RANDREG_fifo_data_OutBUS,
   output logic                 SC_RANDREG_fifo_empty_Out,
   output logic                 SC_RANDREG_fifo_full_Out,
   output logic                 SC_RANDREG_overflow_Out,
   output logic                 SC_RANDREG_load_done_Out
);

   logic                 clk, rst;
   lfsr_mode_e           mode;
   logic [DATAWIDTH-1:0] lfsr_q, lfsr_d, lfsr_step;
   logic [DATAWIDTH-1:0] data_q, data_d;
   logic                 load_prev_q, clear_prev_q;
   logic                 load_done_q;
   logic                 load_evt, clear_evt, capture;

   assign clk  = SC_RANDREG_CLOCK_50;
   assign rst  = SC_RANDREG_RESET_InHigh;
   assign mode = lfsr_mode_e'(SC_RANDREG_mode_In);

   // One-shot events: history holds last cycle's level, so a held-low input fires once.
   assign load_evt  = load_prev_q & ~SC_RANDREG_load_InLow;
   assign clear_evt = clear_prev_q & ~SC_RANDREG_clear_InLow;
   assign capture   = load_evt & ~clear_evt;

   always_comb begin
      lfsr_step = DATAWIDTH'(galois_step(32'(lfsr_q), 32'(TAPS)));
      lfsr_d    = lfsr_q;
      if (lfsr_q == '0) begin
         lfsr_d = SEED;
      end else begin
         case (mode)
            MODE_HOLD: lfsr_d = lfsr_q;
            MODE_RUN:  lfsr_d = lfsr_step;
            MODE_STEP: lfsr_d = SC_RANDREG_step_In ? lfsr_step : lfsr_q;
            MODE_SEED: lfsr_d = (SC_RANDREG_seed_InBUS == '0) ? SEED : SC_RANDREG_seed_InBUS;
            default:   lfsr_d = lfsr_q;
         endcase
      end
   end

   always_comb begin
      data_d = data_q;
      if (clear_evt) begin
         data_d = '0;
      end else if (capture) begin
         data_d = lfsr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q       <= SEED;
         data_q       <= '0;
         load_prev_q  <= 1'b1;
         clear_prev_q <= 1'b1;
         load_done_q  <= 1'b0;
      end else begin
         lfsr_q       <= lfsr_d;
         data_q       <= data_d;
         load_prev_q  <= SC_RANDREG_load_InLow;
         clear_prev_q <= SC_RANDREG_clear_InLow;
         load_done_q  <= capture;
      end
   end

   sc_randreg_fifo #(
      .DATAWIDTH (DATAWIDTH),
      .DEPTH     (DEPTH)
   ) u_fifo (
      .clk_i       (clk),
      .rst_i       (rst),
      .push_i      (capture),
      .push_data_i (lfsr_q),
      .pop_i       (SC_RANDREG_pop_In),
      .flush_i     (clear_evt),
      .head_o      (SC_RANDREG_fifo_data_OutBUS),
      .empty_o     (SC_RANDREG_fifo_empty_Out),
      .full_o      (SC_RANDREG_fifo_full_Out),
      .overflow_o  (SC_RANDREG_overflow_Out)
   );

   assign SC_RANDREG_lfsr_OutBUS   = lfsr_q;
   assign SC_RANDREG_data_OutBUS   = data_q;
   assign SC_RANDREG_load_done_Out = load_done_q;

endmodule

// File: tb/tb_sc_randreg.sv
// Bench for sc_randreg: directed vector table, hand-written corner sequences and
// randomized traffic, all compared against a behavioural model with a queue-based FIFO.
module tb_sc_randreg;

   localparam int         DW    = 8;
   localparam logic [7:0] TAPS  = 8'hB8;
   localparam logic [7:0] SEED  = 8'h01;
   localparam int         DEPTH = 4;

   // clock / reset block
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, clr_n, load_n, step, pop;
   logic [1:0]    mode;
   logic [DW-1:0] seed;
   logic [DW-1:0] lfsr_o, data_o, head_o;
   logic          empty_o, full_o, ovf_o, done_o;

   sc_randreg #(.DATAWIDTH(DW), .TAPS(TAPS), .SEED(SEED), .DEPTH(DEPTH)) dut (
      .SC_RANDREG_CLOCK_50         (clk),
      .SC_RANDREG_RESET_InHigh     (rst),
      .SC_RANDREG_clear_InLow      (clr_n),
      .SC_RANDREG_load_InLow       (load_n),
      .SC_RANDREG_mode_In          (mode),
      .SC_RANDREG_step_In          (step),
      .SC_RANDREG_seed_InBUS       (seed),
      .SC_RANDREG_pop_In           (pop),
      .SC_RANDREG_lfsr_OutBUS      (lfsr_o),
      .SC_RANDREG_data_OutBUS      (data_o),
      .SC_RANDREG_fifo_data_OutBUS (head_o),
      .SC_RANDREG_fifo_empty_Out   (empty_o),
      .SC_RANDREG_fifo_full_Out    (full_o),
      .SC_RANDREG_overflow_Out     (ovf_o),
      .SC_RANDREG_load_done_Out    (done_o)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // reference model state; exp_q is the expected FIFO contents, head at index 0
   logic [DW-1:0] m_lfsr, m_data;
   logic [DW-1:0] exp_q[$];
   logic          m_ovf, m_done, m_lp, m_cp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] lfsr_next(input logic [DW-1:0] s);
      return (s >> 1) ^ ((s % 2 == 1) ? TAPS : 8'h00);
   endfunction

   task automatic model_edge();
      logic          lev, cev;
      logic [DW-1:0] old;
      if (rst) begin
         m_lfsr = SEED; m_data = '0; exp_q.delete();
         m_ovf = 1'b0; m_done = 1'b0; m_lp = 1'b1; m_cp = 1'b1;
      end else begin
         lev = m_lp && !load_n;
         cev = m_cp && !clr_n;
         old = m_lfsr;
         if (old == 0)            m_lfsr = SEED;
         else if (mode == 2'b01)  m_lfsr = lfsr_next(old);
         else if (mode == 2'b10)  m_lfsr = step ? lfsr_next(old) : old;
         else if (mode == 2'b11)  m_lfsr = (seed == 0) ? SEED : seed;
         if (cev) begin
            m_data = '0; exp_q.delete(); m_ovf = 1'b0;
         end else begin
            int had = exp_q.size();
            bit popping = pop && had > 0;
            if (lev) m_data = old;
            if (popping) void'(exp_q.pop_front());
            if (lev) begin
               if (had == DEPTH && !popping) m_ovf = 1'b1;
               else exp_q.push_back(old);
            end
         end
         m_done = lev && !cev;
         m_lp = load_n;
         m_cp = clr_n;
      end
   endtask

   task automatic compare_model();
      check("lfsr", 32'(lfsr_o), 32'(m_lfsr));
      check("data", 32'(data_o), 32'(m_data));
      check("head", 32'(head_o), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'h0);
      check("empty", 32'(empty_o), 32'(exp_q.size() == 0));
      check("full", 32'(full_o), 32'(exp_q.size() == DEPTH));
      check("overflow", 32'(ovf_o), 32'(m_ovf));
      check("load_done", 32'(done_o), 32'(m_done));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      compare_model();
   endtask

   // driver tasks
   task automatic set_idle();
      rst = 1'b0; clr_n = 1'b1; load_n = 1'b1; step = 1'b0; pop = 1'b0; seed = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic load_pulse(input logic stp);
      load_n = 1'b0; step = stp;
      tick();
      load_n = 1'b1; step = 1'b0;
      tick();
   endtask

   typedef struct {
      logic       rst, clr_n, load_n;
      logic [1:0] mode;
      logic [7:0] e_lfsr, e_data, e_head;
      logic       e_empty, e_full, e_ovf, e_done;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic cn, input logic ln, input logic [1:0] md,
                               input logic [7:0] el, input logic [7:0] ed, input logic [7:0] eh,
                               input logic ee, input logic ef, input logic eo, input logic edn);
      vec_t v;
      v.rst = r; v.clr_n = cn; v.load_n = ln; v.mode = md;
      v.e_lfsr = el; v.e_data = ed; v.e_head = eh;
      v.e_empty = ee; v.e_full = ef; v.e_ovf = eo; v.e_done = edn;
      return v;
   endfunction

   vec_t          vecs[20];
   logic [DW-1:0] pop_heads[4];

   initial begin
      set_idle();
      rst  = 1'b1;
      mode = 2'b00;

      // reset, free-run sequence, then a long-held load captured exactly once
      vecs[0] = mk(1, 1, 1, 2'b00, 8'h01, 8'h00, 8'h00, 1, 0, 0, 0);
      vecs[1] = mk(0, 1, 1, 2'b01, 8'hB8, 8'h00, 8'h00, 1, 0, 0, 0);
      vecs[2] = mk(0, 1, 1, 2'b01, 8'h5C, 8'h00, 8'h00, 1, 0, 0, 0);
      vecs[3] = mk(0, 1, 1, 2'b01, 8'h2E, 8'h00, 8'h00, 1, 0, 0, 0);
      vecs[4] = mk(0, 1, 1, 2'b01, 8'h17, 8'h00, 8'h00, 1, 0, 0, 0);
      vecs[5] = mk(0, 1, 1, 2'b01, 8'hB3, 8'h00, 8'h00, 1, 0, 0, 0);
      vecs[6] = mk(1, 1, 1, 2'b00, 8'h01, 8'h00, 8'h00, 1, 0, 0, 0);
      vecs[7] = mk(0, 1, 1, 2'b01, 8'hB8, 8'h00, 8'h00, 1, 0, 0, 0);
      vecs[8] = mk(0, 1, 1, 2'b01, 8'h5C, 8'h00, 8'h00, 1, 0, 0, 0);
      vecs[9] = mk(0, 1, 0, 2'b01, 8'h2E, 8'h5C, 8'h5C, 0, 0, 0, 1);
      for (int i = 10; i < 19; i++) vecs[i] = mk(0, 1, 0, 2'b00, 8'h2E, 8'h5C, 8'h5C, 0, 0, 0, 0);
      vecs[19] = mk(0, 1, 1, 2'b00, 8'h2E, 8'h5C, 8'h5C, 0, 0, 0, 0);

      for (int i = 0; i < 20; i++) begin
         rst = vecs[i].rst; clr_n = vecs[i].clr_n; load_n = vecs[i].load_n; mode = vecs[i].mode;
         tick();
         check($sformatf("vec%0d_lfsr", i), 32'(lfsr_o), 32'(vecs[i].e_lfsr));
         check($sformatf("vec%0d_data", i), 32'(data_o), 32'(vecs[i].e_data));
         check($sformatf("vec%0d_head", i), 32'(head_o), 32'(vecs[i].e_head));
         check($sformatf("vec%0d_empty", i), 32'(empty_o), 32'(vecs[i].e_empty));
         check($sformatf("vec%0d_full", i), 32'(full_o), 32'(vecs[i].e_full));
         check($sformatf("vec%0d_ovf", i), 32'(ovf_o), 32'(vecs[i].e_ovf));
         check($sformatf("vec%0d_done", i), 32'(done_o), 32'(vecs[i].e_done));
      end
      set_idle();

      // fill to full, overflow on the fifth load, then drain
      do_reset();
      mode = 2'b10;
      for (int i = 0; i < 4; i++) load_pulse(1'b1);
      check("fill_full", 32'(full_o), 32'h1);
      check("fill_head", 32'(head_o), 32'h01);
      load_pulse(1'b1);
      check("ovf_set", 32'(ovf_o), 32'h1);
      check("ovf_data", 32'(data_o), 32'h17);
      check("ovf_head", 32'(head_o), 32'h01);
      check("ovf_lfsr", 32'(lfsr_o), 32'hB3);
      pop_heads[0] = 8'hB8; pop_heads[1] = 8'h5C; pop_heads[2] = 8'h2E; pop_heads[3] = 8'h00;
      for (int k = 0; k < 4; k++) begin
         pop = 1'b1;
         tick();
         pop = 1'b0;
         check($sformatf("drain_head%0d", k), 32'(head_o), 32'(pop_heads[k]));
      end
      check("drain_empty", 32'(empty_o), 32'h1);
      check("drain_ovf_sticky", 32'(ovf_o), 32'h1);
      pop = 1'b1;
      tick();
      pop = 1'b0;
      check("pop_empty_ignored", 32'(empty_o), 32'h1);

      // clear and load on the same edge
      do_reset();
      mode = 2'b10; step = 1'b1;
      repeat (3) tick();
      step = 1'b0;
      load_pulse(1'b0);
      check("pre_clear_data", 32'(data_o), 32'h2E);
      check("pre_clear_head", 32'(head_o), 32'h2E);
      clr_n = 1'b0; load_n = 1'b0;
      tick();
      check("clr_data", 32'(data_o), 32'h00);
      check("clr_empty", 32'(empty_o), 32'h1);
      check("clr_ovf", 32'(ovf_o), 32'h0);
      check("clr_done", 32'(done_o), 32'h0);
      clr_n = 1'b1;
      tick();
      check("no_rearm_data", 32'(data_o), 32'h00);
      check("no_rearm_empty", 32'(empty_o), 32'h1);
      load_n = 1'b1;
      tick();
      load_pulse(1'b0);
      check("rearm_data", 32'(data_o), 32'h2E);

      // reseed with zero guard, then hold
      mode = 2'b11; seed = 8'h00;
      tick();
      check("seed0_lfsr", 32'(lfsr_o), 32'h01);
      seed = 8'h3C;
      tick();
      check("seed3c_lfsr", 32'(lfsr_o), 32'h3C);
      mode = 2'b00;
      repeat (3) tick();
      check("hold_lfsr", 32'(lfsr_o), 32'h3C);

      // reset in the middle of activity overrides everything
      do_reset();
      mode = 2'b10;
      repeat (5) load_pulse(1'b1);
      pop = 1'b1;
      tick();
      pop = 1'b0;
      check("mid_ovf", 32'(ovf_o), 32'h1);
      check("mid_lfsr", 32'(lfsr_o), 32'hB3);
      check("mid_full", 32'(full_o), 32'h0);
      check("mid_head", 32'(head_o), 32'hB8);
      rst = 1'b1; load_n = 1'b0; clr_n = 1'b0; pop = 1'b1; mode = 2'b01;
      tick();
      check("rst_lfsr", 32'(lfsr_o), 32'h01);
      check("rst_data", 32'(data_o), 32'h00);
      check("rst_head", 32'(head_o), 32'h00);
      check("rst_empty", 32'(empty_o), 32'h1);
      check("rst_full", 32'(full_o), 32'h0);
      check("rst_ovf", 32'(ovf_o), 32'h0);
      check("rst_done", 32'(done_o), 32'h0);
      set_idle();
      tick();

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rst    = ($urandom_range(0, 199) == 0);
         clr_n  = ($urandom_range(0, 15) != 0);
         load_n = ($urandom_range(0, 3) != 0);
         mode   = 2'($urandom_range(0, 3));
         step   = 1'($urandom_range(0, 1));
         seed   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         pop    = ($urandom_range(0, 3) == 0);
         tick();
      end
      set_idle();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
